reg_file_arb: RTL and testbench

Round-robin arbiter that shares the single-port-pair `reg_file` (one write port, one read port) between `NUM_REQ` requesters. It sits directly in front of `reg_file`, grants at most one access per cycle, registers the winning command onto the register-file strobes, and routes read data back to the requester that issued the read. It also keeps a pipeline of requester IDs so that read responses stay matched to their requester.

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/rr_pick.sv | 28 ++
 rtl/reg_file_arb.sv | 107 ++++++++++
 tb/tb_reg_file_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file widths and the arbiter command word
// Contents: DATA_WIDTH/ADDR_WIDTH defaults and rf_cmd_t {we, addr, data}.
package reg_file_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } rf_cmd_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select, first asserted req at or after ptr
// Ports: req (request vector), ptr (scan start) -> gnt (one-hot), id (encoded winner), any (a winner exists).
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] id,
    output logic          any
);
    logic [PW-1:0] idx;
    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                id       = idx;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_file_arb.sv
// reg_file_arb: round-robin arbiter sharing one reg_file write/read port pair among NUM_REQ requesters
// Ports: clk, rst (async active-high); req/req_we/req_addr/req_wdata (packed per requester),
//        req_lock (only with RF_ARB_LOCK_EN); gnt (combinational one-hot); rsp_valid/rsp_data (registered
//        read response); rf_wr_en/rf_wr_a/rf_wr_d, rf_rd_en/rf_rd_a (registered strobes); rf_rd_d (read data).
// Option: define RF_ARB_LOCK_EN to let a winner hold the grant for up to LOCK_MAX consecutive accesses.
module reg_file_arb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int RD_LAT     = 1,
    parameter int LOCK_MAX   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef RF_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rf_wr_en,
    output logic                          rf_rd_en,
    output logic [ADDR_WIDTH-1:0]         rf_wr_a,
    output logic [ADDR_WIDTH-1:0]         rf_rd_a,
    output logic [DATA_WIDTH-1:0]         rf_wr_d,
    input  logic [DATA_WIDTH-1:0]         rf_rd_d
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]              ptr, win, rd_id;
    logic [NUM_REQ-1:0]         pick;
    logic                       any, hold;
    rf_cmd_t                    cmd;
    logic [RD_LAT-1:0]          pv;
    logic [RD_LAT-1:0][PW-1:0]  pid;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick),
        .id  (win),
        .any (any)
    );

    assign gnt = rst ? '0 : pick;

    always_comb begin
        cmd.we   = req_we[win];
        cmd.addr = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        cmd.data = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef RF_ARB_LOCK_EN
    // hold keeps ptr on the winner; the grant that would bring lock_cnt to LOCK_MAX releases it
    logic [$clog2(LOCK_MAX+1)-1:0] lock_cnt;
    assign hold = any && req_lock[win] && (int'(lock_cnt) + 1 < LOCK_MAX);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_cnt <= '0;
        else     lock_cnt <= hold ? lock_cnt + 1'b1 : '0;
    end
`else
    assign hold = 1'b0;
`endif

    // rd_id travels with rf_rd_en; pv/pid then delay it RD_LAT cycles to line up with rf_rd_d
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            rf_wr_en  <= 1'b0;
            rf_rd_en  <= 1'b0;
            rf_wr_a   <= '0;
            rf_rd_a   <= '0;
            rf_wr_d   <= '0;
            rd_id     <= '0;
            pv        <= '0;
            pid       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            if (any) ptr <= hold ? win : PW'((int'(win) + 1) % NUM_REQ);
            rf_wr_en <= any && cmd.we;
            rf_rd_en <= any && !cmd.we;
            if (any && cmd.we) begin
                rf_wr_a <= cmd.addr;
                rf_wr_d <= cmd.data;
            end
            if (any && !cmd.we) begin
                rf_rd_a <= cmd.addr;
                rd_id   <= win;
            end
            pv[0]  <= rf_rd_en;
            pid[0] <= rd_id;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k]  <= pv[k-1];
                pid[k] <= pid[k-1];
            end
            rsp_valid <= pv[RD_LAT-1] ? NUM_REQ'(1) << pid[RD_LAT-1] : '0;
            if (pv[RD_LAT-1]) rsp_data <= rf_rd_d;
        end
    end
endmodule

// File: tb/tb_reg_file_arb.sv
// tb_reg_file_arb: directed self-checking bench for reg_file_arb with a behavioural reg_file (RD_LAT=2)
module tb_reg_file_arb;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 4;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    req, req_we, gnt, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_data, rf_wr_d, rf_rd_d;
    logic             rf_wr_en, rf_rd_en;
    logic [AW-1:0]    rf_wr_a, rf_rd_a;
`ifdef RF_ARB_LOCK_EN
    logic [NR-1:0]    req_lock;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .RD_LAT(RL), .LOCK_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef RF_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rf_wr_en  (rf_wr_en),
        .rf_rd_en  (rf_rd_en),
        .rf_wr_a   (rf_wr_a),
        .rf_rd_a   (rf_rd_a),
        .rf_wr_d   (rf_wr_d),
        .rf_rd_d   (rf_rd_d)
    );

    // register file model: reset loads mem[a] = C0DE0000 | a, read data valid RL cycles after rf_rd_en
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 256; a++) mem[a] <= 32'hC0DE0000 | a;
        end else if (rf_wr_en) begin
            mem[rf_wr_a] <= rf_wr_d;
        end
        rd_pipe[0] <= mem[rf_rd_a];
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign rf_rd_d = rd_pipe[RL-1];

    task automatic drive(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset;
        logic [127:0] outs;
        req = '1;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        req = '0;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            outs = {gnt, rsp_valid, rsp_data, rf_wr_en, rf_rd_en, rf_wr_a, rf_rd_a, rf_wr_d};
            checks++;
            if (outs !== '0) begin errors++; $display("FAIL idle_outputs cycle %0d: got %h expected 0", c, outs); end
            checks++;
            if (dut.ptr !== 2'd0) begin errors++; $display("FAIL idle_ptr cycle %0d: got %0d expected 0", c, dut.ptr); end
        end
    endtask

    task automatic test_write_read;
        logic [3:0] er;
        @(negedge clk);
        drive(1, 1'b1, 8'd3, 32'hA102FFFF);
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL wr_gnt: got %b expected 0010", gnt); end
        @(negedge clk);
        req = '0;
        checks++;
        if ({rf_wr_en, rf_rd_en, rf_wr_a, rf_wr_d} !== {1'b1, 1'b0, 8'd3, 32'hA102FFFF}) begin
            errors++;
            $display("FAIL wr_strobe: got we=%b re=%b a=%h d=%h expected we=1 re=0 a=03 d=a102ffff", rf_wr_en, rf_rd_en, rf_wr_a, rf_wr_d);
        end
        @(negedge clk);
        drive(1, 1'b0, 8'd3, 32'h0);
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL rd_gnt: got %b expected 0010", gnt); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            req = '0;
            #1;
            if (c <= 2) begin
                checks++;
                if ({rf_rd_en, rf_wr_en} !== {c == 1, 1'b0}) begin
                    errors++;
                    $display("FAIL rd_strobe cycle %0d: got re=%b we=%b expected re=%0d we=0", c, rf_rd_en, rf_wr_en, c == 1);
                end
            end
            if (c == 1) begin
                checks++;
                if (rf_rd_a !== 8'd3) begin errors++; $display("FAIL rd_addr: got %h expected 03", rf_rd_a); end
            end
            er = (c == 4) ? 4'b0010 : 4'b0000;
            checks++;
            if (rsp_valid !== er) begin errors++; $display("FAIL wr_rd_rsp_valid cycle %0d: got %b expected %b", c, rsp_valid, er); end
            if (c >= 4) begin
                checks++;
                if (rsp_data !== 32'hA102FFFF) begin errors++; $display("FAIL wr_rd_rsp_data cycle %0d: got %h expected a102ffff", c, rsp_data); end
            end
        end
    endtask

    task automatic test_all_read;
        logic [3:0] eg, er;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) drive(i, 1'b0, AW'(10 + i), 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            eg = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b expected %b", c, gnt, eg); end
            er = (c >= 4) ? 4'(1 << ((c - 4) % 4)) : 4'b0000;
            checks++;
            if (rsp_valid !== er) begin errors++; $display("FAIL rr_rsp_valid cycle %0d: got %b expected %b", c, rsp_valid, er); end
            if (c >= 4) begin
                checks++;
                if (rsp_data !== 32'hC0DE0000 + 10 + (c - 4) % 4) begin
                    errors++;
                    $display("FAIL rr_rsp_data cycle %0d: got %h expected %h", c, rsp_data, 32'hC0DE0000 + 10 + (c - 4) % 4);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid;
        logic [127:0] outs;
        @(negedge clk);
        drive(0, 1'b0, 8'd20, 32'h0);
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b expected 0001", gnt); end
        @(negedge clk);
        req = '0;
        checks++;
        if (rf_rd_en !== 1'b1) begin errors++; $display("FAIL mid_rd_en: got %b expected 1", rf_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {gnt, rsp_valid, rsp_data, rf_wr_en, rf_rd_en, rf_wr_a, rf_rd_a, rf_wr_d};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_rsp cycle %0d: got %b expected 0000", c, rsp_valid); end
        end
    endtask

    task automatic test_raw;
        logic [3:0] er;
        @(negedge clk);
        drive(2, 1'b1, 8'd200, 32'h12345678);
        req = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL raw_pre_gnt: got %b expected 0100", gnt); end
        @(negedge clk);
        drive(3, 1'b1, 8'd111, 32'h5555FFFF);
        drive(0, 1'b0, 8'd111, 32'h0);
        req = 4'b1001;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL raw_wr_gnt: got %b expected 1000", gnt); end
        @(negedge clk);
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL raw_rd_gnt: got %b expected 0001", gnt); end
        checks++;
        if ({rf_wr_en, rf_wr_a, rf_wr_d} !== {1'b1, 8'd111, 32'h5555FFFF}) begin
            errors++;
            $display("FAIL raw_wr_strobe: got we=%b a=%h d=%h expected we=1 a=6f d=5555ffff", rf_wr_en, rf_wr_a, rf_wr_d);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req = '0;
            #1;
            er = (c == 4) ? 4'b0001 : 4'b0000;
            checks++;
            if (rsp_valid !== er) begin errors++; $display("FAIL raw_rsp_valid cycle %0d: got %b expected %b", c, rsp_valid, er); end
            if (c == 4) begin
                checks++;
                if (rsp_data !== 32'h5555FFFF) begin errors++; $display("FAIL raw_rsp_data: got %h expected 5555ffff", rsp_data); end
            end
        end
    endtask

`ifdef RF_ARB_LOCK_EN
    task automatic test_lock;
        logic [3:0] eg;
        drive(2, 1'b0, 8'd30, 32'h0);
        drive(0, 1'b0, 8'd31, 32'h0);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req      = 4'b0101;
            req_lock = 4'b0100;
            #1;
            eg = (c < 8) ? 4'b0100 : 4'b0001;
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL lock_gnt cycle %0d: got %b expected %b", c, gnt, eg); end
        end
        @(negedge clk);
        req      = '0;
        req_lock = '0;
        repeat (6) @(negedge clk);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef RF_ARB_LOCK_EN
        req_lock  = '0;
`endif
        test_reset;
        test_write_read;
        test_all_read;
        test_reset_mid;
        test_raw;
`ifdef RF_ARB_LOCK_EN
        test_lock;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
